// File: rtl/clk_rst_monitor.sv
// clk_rst_monitor: measures the period of an asynchronous monitored clock and
// the low width of an asynchronous monitored reset, in sys_clk cycles, and
// raises sticky flags for out-of-range periods, clock loss and short resets.
module clk_rst_monitor #(
  parameter int CNT_W          = 16,
  parameter int MIN_PERIOD     = 4,
  parameter int MAX_PERIOD     = 16,
  parameter int MIN_RST_CYCLES = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             mon_en,
  input  logic             mon_clk,
  input  logic             mon_rst_n,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] rst_width,
  output logic             rst_width_vld,
  output logic             clk_alive,
  output logic             err_period,
  output logic             err_timeout,
  output logic             err_rst_short
);

  localparam logic [CNT_W-1:0] L_MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] L_MAX_P = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] L_MIN_R = CNT_W'(MIN_RST_CYCLES);

  typedef enum logic {C_IDLE, C_MEASURE} cst_t;
  typedef enum logic {R_RUN, R_IN_RST}   rst_t;

  logic             r_clk_s1, r_clk_s2, r_clk_h;
  logic             r_rst_s1, r_rst_s2, r_rst_h;
  cst_t             r_cst, w_cst_nxt;
  rst_t             r_rst, w_rst_nxt;
  logic [CNT_W-1:0] r_pcnt, r_rcnt;
  logic [CNT_W-1:0] r_period, r_rst_width;
  logic             r_period_vld, r_rst_width_vld, r_alive;
  logic             r_err_period, r_err_timeout, r_err_rst_short;

  logic w_clk_rise, w_rst_deassert, w_timeout;
  logic w_pmeas, w_perr, w_rst_entry, w_rmeas, w_rshort;

  assign w_clk_rise     = r_clk_s2 & ~r_clk_h;
  assign w_rst_deassert = r_rst_s2 & ~r_rst_h;

  // Synchronizers plus history flops; clock idles low, reset idles high
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_clk_s1 <= 1'b0; r_clk_s2 <= 1'b0; r_clk_h <= 1'b0;
      r_rst_s1 <= 1'b1; r_rst_s2 <= 1'b1; r_rst_h <= 1'b1;
    end else begin
      r_clk_s1 <= mon_clk;   r_clk_s2 <= r_clk_s1; r_clk_h <= r_clk_s2;
      r_rst_s1 <= mon_rst_n; r_rst_s2 <= r_rst_s1; r_rst_h <= r_rst_s2;
    end
  end

  // Clock FSM next state; a rise in the threshold cycle beats the timeout
  always_comb begin
    w_cst_nxt = r_cst;
    w_timeout = 1'b0;
    if (!mon_en) begin
      w_cst_nxt = C_IDLE;
    end else begin
      case (r_cst)
        C_IDLE:    if (w_clk_rise) w_cst_nxt = C_MEASURE;
        C_MEASURE: if (!w_clk_rise && r_pcnt == L_MAX_P) begin
                     w_timeout = 1'b1;
                     w_cst_nxt = C_IDLE;
                   end
        default:   w_cst_nxt = C_IDLE;
      endcase
    end
  end

  // Reset FSM next state
  always_comb begin
    w_rst_nxt = r_rst;
    if (!mon_en) begin
      w_rst_nxt = R_RUN;
    end else begin
      case (r_rst)
        R_RUN:    if (!r_rst_s2) w_rst_nxt = R_IN_RST;
        R_IN_RST: if (w_rst_deassert) w_rst_nxt = R_RUN;
        default:  w_rst_nxt = R_RUN;
      endcase
    end
  end

  // Measurement events, evaluated in the cycle they are detected
  always_comb begin
    w_pmeas     = mon_en && (r_cst == C_MEASURE) && w_clk_rise;
    w_perr      = w_pmeas && ((r_pcnt < L_MIN_P) || (r_pcnt > L_MAX_P));
    w_rst_entry = mon_en && (r_rst == R_RUN) && !r_rst_s2;
    w_rmeas     = mon_en && (r_rst == R_IN_RST) && w_rst_deassert;
    w_rshort    = w_rmeas && (r_rcnt < L_MIN_R);
  end

  // State registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cst <= C_IDLE;
      r_rst <= R_RUN;
    end else begin
      r_cst <= w_cst_nxt;
      r_rst <= w_rst_nxt;
    end
  end

  // Period counter: cycles since last rise, saturating
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !mon_en)  r_pcnt <= '0;
    else if (w_clk_rise)     r_pcnt <= CNT_W'(1);
    else if (!(&r_pcnt))     r_pcnt <= r_pcnt + 1'b1;
  end

  // Reset-width counter: 1 in the entry cycle, counts while in IN_RST
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !mon_en)  r_rcnt <= '0;
    else if (w_rst_entry)    r_rcnt <= CNT_W'(1);
    else if (r_rst == R_IN_RST) begin
      if (!(&r_rcnt))        r_rcnt <= r_rcnt + 1'b1;
    end else                 r_rcnt <= '0;
  end

  // Captured results, valid pulses and liveness
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_period        <= '0;
      r_rst_width     <= '0;
      r_period_vld    <= 1'b0;
      r_rst_width_vld <= 1'b0;
      r_alive         <= 1'b0;
    end else begin
      r_period_vld    <= w_pmeas;
      r_rst_width_vld <= w_rmeas;
      if (w_pmeas) r_period    <= r_pcnt;
      if (w_rmeas) r_rst_width <= r_rcnt;
      if (!mon_en || w_timeout)   r_alive <= 1'b0;
      else if (w_pmeas && !w_perr) r_alive <= 1'b1;
    end
  end

  // Sticky errors; a new event outranks a same-cycle clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_err_period    <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_err_rst_short <= 1'b0;
    end else begin
      r_err_period    <= w_perr    | (r_err_period    & ~clr_err);
      r_err_timeout   <= w_timeout | (r_err_timeout   & ~clr_err);
      r_err_rst_short <= w_rshort  | (r_err_rst_short & ~clr_err);
    end
  end

  assign period        = r_period;
  assign period_vld    = r_period_vld;
  assign rst_width     = r_rst_width;
  assign rst_width_vld = r_rst_width_vld;
  assign clk_alive     = r_alive;
  assign err_period    = r_err_period;
  assign err_timeout   = r_err_timeout;
  assign err_rst_short = r_err_rst_short;

endmodule

// File: tb/tb_clk_rst_monitor.sv
// Directed bench for clk_rst_monitor: period, timeout, short period, clear
// priority, reset width, disable and mid-measurement sys_rst.
module tb_clk_rst_monitor;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        mon_en = 1'b0, mon_clk = 1'b0, mon_rst_n = 1'b1, clr_err = 1'b0;
  logic [15:0] period, rst_width;
  logic        period_vld, rst_width_vld, clk_alive;
  logic        err_period, err_timeout, err_rst_short;

  int          ncmp = 0, nfail = 0, n_pvld = 0, n_rvld = 0;
  logic [15:0] last_p = '0, last_r = '0;

  clk_rst_monitor #(.CNT_W(16), .MIN_PERIOD(4), .MAX_PERIOD(16), .MIN_RST_CYCLES(10)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mon_en(mon_en), .mon_clk(mon_clk),
    .mon_rst_n(mon_rst_n), .clr_err(clr_err), .period(period), .period_vld(period_vld),
    .rst_width(rst_width), .rst_width_vld(rst_width_vld), .clk_alive(clk_alive),
    .err_period(err_period), .err_timeout(err_timeout), .err_rst_short(err_rst_short)
  );

  always #5 sys_clk = ~sys_clk;

  // Record valid pulses away from the active edge
  always @(negedge sys_clk) begin
    if (period_vld)    begin n_pvld <= n_pvld + 1; last_p <= period;    end
    if (rst_width_vld) begin n_rvld <= n_rvld + 1; last_r <= rst_width; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic mpulse(input int hi, input int lo);
    mon_clk = 1'b1; tick(hi);
    mon_clk = 1'b0; tick(lo);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_period",     32'(period), 0);
    chk("rst_rst_width",  32'(rst_width), 0);
    chk("rst_pvld",       32'(period_vld), 0);
    chk("rst_rvld",       32'(rst_width_vld), 0);
    chk("rst_alive",      32'(clk_alive), 0);
    chk("rst_err_period", 32'(err_period), 0);
    chk("rst_err_tmo",    32'(err_timeout), 0);
    chk("rst_err_short",  32'(err_rst_short), 0);
    sys_rst = 1'b0; mon_en = 1'b1;
    tick(2);

    // Period 8: first rise arms, four measurements follow
    repeat (5) mpulse(4, 4);
    chk("p8_count",   32'(n_pvld), 4);
    chk("p8_period",  32'(last_p), 8);
    chk("p8_alive",   32'(clk_alive), 1);
    chk("p8_err_per", 32'(err_period), 0);
    chk("p8_err_tmo", 32'(err_timeout), 0);

    // Clock stops: timeout lands 16 cycles after the last detected rise
    tick(10);
    chk("tmo_before",       32'(err_timeout), 0);
    chk("tmo_alive_before", 32'(clk_alive), 1);
    tick(1);
    chk("tmo_flag",  32'(err_timeout), 1);
    chk("tmo_alive", 32'(clk_alive), 0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("tmo_clr", 32'(err_timeout), 0);

    // Period 2: too short
    repeat (4) mpulse(1, 1);
    tick(3);
    chk("p2_count",   32'(n_pvld), 7);
    chk("p2_period",  32'(last_p), 2);
    chk("p2_err_per", 32'(err_period), 1);
    chk("p2_alive",   32'(clk_alive), 0);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    chk("p2_clr", 32'(err_period), 0);

    // Clear coinciding with a new short-period event: event wins
    mpulse(1, 1);                 // period 6, valid
    mon_clk = 1'b1; tick(1);
    mon_clk = 1'b0; tick(1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;  // period 2 captured this edge
    chk("clr_vs_evt_flag",   32'(err_period), 1);
    chk("clr_vs_evt_period", 32'(period), 2);
    chk("clr_vs_evt_alive",  32'(clk_alive), 1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;

    // Reset widths 14 (legal) and 5 (short)
    mon_rst_n = 1'b0; tick(14); mon_rst_n = 1'b1; tick(4);
    chk("rw14_count", 32'(n_rvld), 1);
    chk("rw14_width", 32'(last_r), 14);
    chk("rw14_err",   32'(err_rst_short), 0);
    mon_rst_n = 1'b0; tick(5); mon_rst_n = 1'b1; tick(4);
    chk("rw5_count", 32'(n_rvld), 2);
    chk("rw5_width", 32'(last_r), 5);
    chk("rw5_err",   32'(err_rst_short), 1);

    // Disabled: no measurements, results held
    mon_en = 1'b0;
    repeat (3) mpulse(4, 4);
    mon_rst_n = 1'b0; tick(12); mon_rst_n = 1'b1; tick(4);
    chk("dis_pcount", 32'(n_pvld), 9);
    chk("dis_rcount", 32'(n_rvld), 2);
    chk("dis_period", 32'(period), 2);
    chk("dis_width",  32'(rst_width), 5);
    chk("dis_err",    32'(err_rst_short), 1);

    // sys_rst in the middle of a measurement
    mon_en = 1'b1; tick(2);
    repeat (2) mpulse(4, 4);
    mon_clk = 1'b1; tick(4);
    mon_clk = 1'b0; tick(2);
    chk("pre_srst_count", 32'(n_pvld), 11);
    sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
    chk("srst_period",    32'(period), 0);
    chk("srst_width",     32'(rst_width), 0);
    chk("srst_pvld",      32'(period_vld), 0);
    chk("srst_alive",     32'(clk_alive), 0);
    chk("srst_err_per",   32'(err_period), 0);
    chk("srst_err_tmo",   32'(err_timeout), 0);
    chk("srst_err_short", 32'(err_rst_short), 0);
    tick(2);
    chk("srst_no_vld", 32'(n_pvld), 11);
    mpulse(4, 4);
    chk("post_first_rise", 32'(n_pvld), 11);
    mpulse(4, 4);
    chk("post_second_rise", 32'(n_pvld), 12);
    chk("post_period",      32'(last_p), 8);
    chk("post_alive",       32'(clk_alive), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/clk_rst_monitor.md
CLK_RST_MONITOR -- requirements
Module: clk_rst_monitor

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of all cycle counters and measured outputs.
REQ-002 SHALL have parameter MIN_PERIOD, 4, smallest legal mon_clk period in sys_clk cycles.
REQ-003 SHALL have parameter MAX_PERIOD, 16, largest legal mon_clk period and the timeout threshold in sys_clk cycles.
REQ-004 SHALL have parameter MIN_RST_CYCLES, 10, smallest legal mon_rst_n low width in sys_clk cycles.
REQ-005 SHALL have port sys_clk  in  1  the only clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port mon_en  in  1  level; monitoring enabled when 1.
REQ-008 SHALL have port mon_clk  in  1  observed clock, treated as asynchronous data.
REQ-009 SHALL have port mon_rst_n  in  1  observed active-low reset, asynchronous data.
REQ-010 SHALL have port clr_err  in  1  single-cycle pulse; clears sticky error flags.
REQ-011 SHALL have port period  out  CNT_W  last measured mon_clk period in sys_clk cycles.
REQ-012 SHALL have port period_vld  out  1  single-cycle pulse when period updates.
REQ-013 SHALL have port rst_width  out  CNT_W  last measured mon_rst_n low width in sys_clk cycles.
REQ-014 SHALL have port rst_width_vld  out  1  single-cycle pulse when rst_width updates.
REQ-015 SHALL have port clk_alive  out  1  1 while mon_clk edges arrive within MAX_PERIOD.
REQ-016 SHALL have port err_period  out  1  sticky; a measured period was outside [MIN_PERIOD, MAX_PERIOD].
REQ-017 SHALL have port err_timeout  out  1  sticky; no mon_clk rise for MAX_PERIOD cycles.
REQ-018 SHALL have port err_rst_short  out  1  sticky; a mon_rst_n low pulse was shorter than MIN_RST_CYCLES.

Function
REQ-019 SHALL pass mon_clk and mon_rst_n through 2-flop synchronizers plus one history flop; a rise is detected when sync=1 and history=0, and a deassertion when rst sync=1 and history=0.
REQ-020 SHALL use a clock FSM with states IDLE and MEASURE: IDLE->MEASURE on the first detected rise with mon_en=1; MEASURE->IDLE on timeout or mon_en=0.
REQ-021 SHALL load the period counter with 1 on every detected rise and otherwise increment it, saturating at all-ones.
REQ-022 SHALL, on a detected rise in MEASURE, register period=counter value (cycles since previous rise) and pulse period_vld the next cycle with period valid in that same cycle.
REQ-023 SHALL set err_period when the period captured in REQ-022 is <MIN_PERIOD or >MAX_PERIOD.
REQ-024 SHALL, in MEASURE, set err_timeout, clear clk_alive and go to IDLE when the counter reaches MAX_PERIOD with no rise in that cycle; a rise in the same cycle takes precedence and no timeout is flagged.
REQ-025 SHALL set clk_alive on the first valid period_vld (no err_period) and clear it on timeout, mon_en=0 or sys_rst.
REQ-026 SHALL use a reset FSM with states RUN and IN_RST: RUN->IN_RST when the rst sync goes 0 with mon_en=1; IN_RST->RUN on detected deassertion or mon_en=0.
REQ-027 SHALL count sys_clk cycles while in IN_RST, starting at 1 in the entry cycle, saturating at all-ones.
REQ-028 SHALL, on deassertion in IN_RST, register rst_width=count, pulse rst_width_vld one cycle, and set err_rst_short if count <MIN_RST_CYCLES.
REQ-029 SHALL, when mon_en=0, hold both FSMs in IDLE/RUN, clear counters, produce no vld pulses, and keep period, rst_width and sticky flags unchanged.
REQ-030 SHALL clear all three sticky flags on clr_err; an error event in the same cycle wins and the flag reads 1.
REQ-031 SHALL keep the clock and reset measurement paths independent; simultaneous events on both are each handled in that cycle.

Reset
REQ-032 SHALL, on sys_rst=1 at a sys_clk edge, set period, rst_width, all vld pulses, clk_alive and all error flags to 0, clock sync/history flops to 0, rst sync/history flops to 1, and FSMs to IDLE/RUN.
REQ-033 SHALL abandon any in-progress measurement on sys_rst without a vld pulse, and require a fresh first rise before measuring again.

Verification
REQ-034 SHALL verify: mon_en=1, mon_clk period 8 sys_clk cycles -> period=8 on each period_vld, clk_alive=1, no errors.
REQ-035 SHALL verify: mon_clk stuck after a rise -> err_timeout=1 and clk_alive=0 exactly 16 cycles after the last detected rise.
REQ-036 SHALL verify: mon_clk period 2 -> period=2, err_period=1; clr_err without new error -> err_period=0 next cycle.
REQ-037 SHALL verify: mon_rst_n low 14 cycles -> rst_width=14, no error; low 5 cycles -> rst_width=5, err_rst_short=1.
REQ-038 SHALL verify: clr_err in the same cycle as an err_period event -> err_period stays 1.
REQ-039 SHALL verify: sys_rst asserted mid-measurement -> all outputs 0 next cycle, no vld pulse, first post-reset rise gives no period_vld.
